// File: rtl/lbm_divider_if.sv
// Operand/result bundle between the LBM controller and the moment-stage divider.
interface lbm_divider_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  div_start;
    logic [DATA_WIDTH-1:0] dividend_x;
    logic [DATA_WIDTH-1:0] dividend_y;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  div_valid;
    logic [DATA_WIDTH-1:0] quot_x;
    logic [DATA_WIDTH-1:0] quot_y;
    logic                  div_busy;
    logic                  div_by_zero;

    // Controller side: issues requests, consumes quotients.
    modport master (
        output div_start, dividend_x, dividend_y, divisor,
        input  div_valid, quot_x, quot_y, div_busy, div_by_zero
    );

    // Divider side.
    modport slave (
        input  div_start, dividend_x, dividend_y, divisor,
        output div_valid, quot_x, quot_y, div_busy, div_by_zero
    );

endinterface

// File: rtl/lbm_divider.sv
// Two-lane iterative signed fixed-point divider (ux = pux/p, uy = puy/p).
// Restoring shift-subtract on magnitudes, one quotient bit per lane per cycle,
// sign applied and result saturated at the end.
module lbm_divider #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned ITER       = DATA_WIDTH + FRAC_BITS
) (
    input logic          Clk,
    input logic          Reset,
    lbm_divider_if.slave bus
);

    localparam int unsigned CW = $clog2(ITER);
    localparam int unsigned UW = ITER - DATA_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [ITER-1:0]       num_x_q, num_y_q;
    logic [ITER-1:0]       qt_x_q, qt_y_q;
    logic [DATA_WIDTH:0]   rem_x_q, rem_y_q;
    logic [DATA_WIDTH-1:0] dmag_q;
    logic                  neg_x_q, neg_y_q, dbz_q;
    logic [DATA_WIDTH-1:0] quot_x_q, quot_y_q;

    logic [DATA_WIDTH+1:0] sh_x, sh_y;
    logic                  ge_x, ge_y;
    logic [DATA_WIDTH:0]   rem_x_d, rem_y_d;

    // Two's complement magnitude; the most negative value maps to 2^(W-1).
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Apply the result sign and clamp to the representable range.
    function automatic logic [DATA_WIDTH-1:0] lane_fix(input logic [ITER-1:0] mag,
                                                       input logic neg);
        logic [UW-1:0]         upper;
        logic [DATA_WIDTH-2:0] low;
        upper = mag[ITER-1:DATA_WIDTH-1];
        low   = mag[DATA_WIDTH-2:0];
        if (!neg) begin
            if (upper != '0) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
            return mag[DATA_WIDTH-1:0];
        end
        if (upper > UW'(1) || (upper == UW'(1) && low != '0)) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return ~mag[DATA_WIDTH-1:0] + 1'b1;
    endfunction

    // One restoring step per lane: shift in next numerator bit, subtract if it fits.
    always_comb begin
        sh_x    = {rem_x_q, num_x_q[ITER-1]};
        sh_y    = {rem_y_q, num_y_q[ITER-1]};
        ge_x    = sh_x >= {2'b00, dmag_q};
        ge_y    = sh_y >= {2'b00, dmag_q};
        rem_x_d = ge_x ? (sh_x[DATA_WIDTH:0] - {1'b0, dmag_q}) : sh_x[DATA_WIDTH:0];
        rem_y_d = ge_y ? (sh_y[DATA_WIDTH:0] - {1'b0, dmag_q}) : sh_y[DATA_WIDTH:0];
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_d       = state_q;
        bus.div_valid = 1'b0;
        bus.div_busy  = 1'b1;
        unique case (state_q)
            StIdle: begin
                bus.div_busy = 1'b0;
                if (bus.div_start) state_d = (bus.divisor == '0) ? StFix : StRun;
            end
            StRun:   if (cnt_q == CW'(ITER - 1)) state_d = StFix;
            StFix:   state_d = StDone;
            StDone: begin
                bus.div_valid = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= '0;
            num_x_q  <= '0;
            num_y_q  <= '0;
            qt_x_q   <= '0;
            qt_y_q   <= '0;
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            dmag_q   <= '0;
            neg_x_q  <= 1'b0;
            neg_y_q  <= 1'b0;
            dbz_q    <= 1'b0;
            quot_x_q <= '0;
            quot_y_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.div_start) begin
                        cnt_q    <= '0;
                        num_x_q  <= {magnitude(bus.dividend_x), {FRAC_BITS{1'b0}}};
                        num_y_q  <= {magnitude(bus.dividend_y), {FRAC_BITS{1'b0}}};
                        qt_x_q   <= '0;
                        qt_y_q   <= '0;
                        rem_x_q  <= '0;
                        rem_y_q  <= '0;
                        dmag_q   <= magnitude(bus.divisor);
                        neg_x_q  <= bus.dividend_x[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1];
                        neg_y_q  <= bus.dividend_y[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1];
                        dbz_q    <= (bus.divisor == '0);
                        quot_x_q <= '0;
                        quot_y_q <= '0;
                    end
                end
                StRun: begin
                    cnt_q   <= cnt_q + 1'b1;
                    num_x_q <= num_x_q << 1;
                    num_y_q <= num_y_q << 1;
                    rem_x_q <= rem_x_d;
                    rem_y_q <= rem_y_d;
                    qt_x_q  <= {qt_x_q[ITER-2:0], ge_x};
                    qt_y_q  <= {qt_y_q[ITER-2:0], ge_y};
                end
                StFix: begin
                    quot_x_q <= dbz_q ? '0 : lane_fix(qt_x_q, neg_x_q);
                    quot_y_q <= dbz_q ? '0 : lane_fix(qt_y_q, neg_y_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.quot_x      = quot_x_q;
    assign bus.quot_y      = quot_y_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_lbm_divider.sv
// Directed bench for lbm_divider: hand-computed Q16.16 quotients and cycle timing.
module tb_lbm_divider;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    lbm_divider_if #(.DATA_WIDTH(32)) bus ();

    lbm_divider #(
        .DATA_WIDTH(32),
        .FRAC_BITS (16)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and track it cycle by cycle. Cycle 0 is the accept cycle.
    // inj >= 0 raises a second start with other operands in that cycle.
    task automatic run_op(input string tag, input logic [31:0] dx, input logic [31:0] dy,
                          input logic [31:0] dv, input int vcyc, input logic [31:0] qx,
                          input logic [31:0] qy, input logic dbz, input int inj);
        int valid_cnt;
        int valid_at;
        int busy_err;
        valid_cnt = 0;
        valid_at  = -1;
        busy_err  = 0;
        @(posedge Clk);
        #1;
        bus.div_start  = 1'b1;
        bus.dividend_x = dx;
        bus.dividend_y = dy;
        bus.divisor    = dv;
        for (int c = 0; c <= vcyc + 5; c++) begin
            @(negedge Clk);
            if (bus.div_valid) begin
                valid_cnt++;
                valid_at = c;
            end
            if (bus.div_busy !== ((c >= 1) && (c <= vcyc))) busy_err++;
            if (c == 1) check_eq({tag, " dbz_early"}, 64'(bus.div_by_zero), 64'(dv == 0));
            if (c == vcyc) begin
                check_eq({tag, " quot_x"}, 64'(bus.quot_x), 64'(qx));
                check_eq({tag, " quot_y"}, 64'(bus.quot_y), 64'(qy));
                check_eq({tag, " dbz"}, 64'(bus.div_by_zero), 64'(dbz));
            end
            if (c == vcyc + 5) begin
                check_eq({tag, " held_x"}, 64'(bus.quot_x), 64'(qx));
                check_eq({tag, " held_y"}, 64'(bus.quot_y), 64'(qy));
            end
            @(posedge Clk);
            #1;
            bus.div_start = 1'b0;
            if (c + 1 == inj) begin
                bus.div_start  = 1'b1;
                bus.dividend_x = 32'h0005_0000;
                bus.dividend_y = 32'h0007_0000;
                bus.divisor    = 32'h0001_0000;
            end
        end
        check_eq({tag, " valid_count"}, 64'(valid_cnt), 64'd1);
        check_eq({tag, " valid_cycle"}, 64'(valid_at), 64'(vcyc));
        check_eq({tag, " busy_window"}, 64'(busy_err), 64'd0);
    endtask

    initial begin
        int stray_valid;
        n_checks       = 0;
        n_fail         = 0;
        Reset          = 1'b1;
        bus.div_start  = 1'b0;
        bus.dividend_x = '0;
        bus.dividend_y = '0;
        bus.divisor    = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst valid", 64'(bus.div_valid), 64'd0);
        check_eq("rst busy", 64'(bus.div_busy), 64'd0);
        check_eq("rst dbz", 64'(bus.div_by_zero), 64'd0);
        check_eq("rst quot_x", 64'(bus.quot_x), 64'd0);
        check_eq("rst quot_y", 64'(bus.quot_y), 64'd0);
        Reset = 1'b0;

        // 3/2 = 1.5, -1/2 = -0.5
        run_op("basic", 32'h0003_0000, 32'hFFFF_0000, 32'h0002_0000, 50,
               32'h0001_8000, 32'hFFFF_8000, 1'b0, -1);
        // 1/3 truncated toward zero in both signs
        run_op("trunc", 32'h0001_0000, 32'hFFFF_0000, 32'h0003_0000, 50,
               32'h0000_5555, 32'hFFFF_AAAB, 1'b0, -1);
        // 32767/(1/256) and -32768/(1/256) overflow both ways
        run_op("sat", 32'h7FFF_0000, 32'h8000_0000, 32'h0000_0100, 50,
               32'h7FFF_FFFF, 32'h8000_0000, 1'b0, -1);
        // Exactly representable extremes with divisor 1.0
        run_op("edge_one", 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 50,
               32'h8000_0000, 32'h7FFF_FFFF, 1'b0, -1);
        // Negative divisor: -32768/-1 saturates positive, 5/-1 = -5
        run_op("neg_div", 32'h8000_0000, 32'h0005_0000, 32'hFFFF_0000, 50,
               32'h7FFF_FFFF, 32'hFFFB_0000, 1'b0, -1);
        run_op("div0", 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 2,
               32'h0000_0000, 32'h0000_0000, 1'b1, -1);
        // Valid start after divide-by-zero clears the flag
        run_op("after0", 32'h0006_0000, 32'h0000_0000, 32'h0002_0000, 50,
               32'h0003_0000, 32'h0000_0000, 1'b0, -1);
        // Second start in cycle 10 must be ignored
        run_op("ignore", 32'h0003_0000, 32'hFFFF_0000, 32'h0002_0000, 50,
               32'h0001_8000, 32'hFFFF_8000, 1'b0, 10);

        // Reset in cycle 20 of a running operation
        @(posedge Clk);
        #1;
        bus.div_start  = 1'b1;
        bus.dividend_x = 32'h0001_0000;
        bus.dividend_y = 32'h0002_0000;
        bus.divisor    = 32'h0004_0000;
        @(posedge Clk);
        #1;
        bus.div_start = 1'b0;
        repeat (19) @(posedge Clk);
        #1;
        check_eq("mid busy_before", 64'(bus.div_busy), 64'd1);
        Reset = 1'b1;
        #1;
        check_eq("mid valid", 64'(bus.div_valid), 64'd0);
        check_eq("mid busy", 64'(bus.div_busy), 64'd0);
        check_eq("mid dbz", 64'(bus.div_by_zero), 64'd0);
        check_eq("mid quot_x", 64'(bus.quot_x), 64'd0);
        check_eq("mid quot_y", 64'(bus.quot_y), 64'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset       = 1'b0;
        stray_valid = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            if (bus.div_valid) stray_valid++;
        end
        check_eq("mid no_valid", 64'(stray_valid), 64'd0);
        // 1/4 = 0.25, 2/4 = 0.5
        run_op("post_rst", 32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 50,
               32'h0000_4000, 32'h0000_8000, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lbm_divider.md
# lbm_divider

Iterative fixed-point divider for the LBM moment stage. It answers the controller's `div_start`/`div_valid` handshake by dividing momentum by density (`ux = pux/p`, `uy = puy/p`) in two lanes that share one divisor. It accepts operands on a one-cycle `div_start` pulse, runs a shift-subtract loop, and returns both quotients with a single-cycle `div_valid` pulse. The quotients then stay stable so the controller can load its UX/UY registers on the following cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width; signed two's complement fixed point.
- FRAC_BITS, 16, fractional bits (default format Q16.16).
- ITER, DATA_WIDTH+FRAC_BITS, iteration count (derived; do not override).

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- div_start  input  1  start request; sampled only in IDLE.
- dividend_x  input  DATA_WIDTH  signed x-momentum (pux); captured on an accepted start.
- dividend_y  input  DATA_WIDTH  signed y-momentum (puy); captured on an accepted start.
- divisor  input  DATA_WIDTH  signed density (p); captured on an accepted start.
- div_valid  output  1  one-cycle pulse when the results are ready.
- quot_x  output  DATA_WIDTH  signed dividend_x/divisor; held until the next accepted start.
- quot_y  output  DATA_WIDTH  signed dividend_y/divisor; held until the next accepted start.
- div_busy  output  1  high in every state except IDLE.
- div_by_zero  output  1  flag for the last operation; cleared on the next accepted start.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If div_start=1, capture the operands, sign bits and unsigned magnitudes (DATA_WIDTH bits; |−2^(W−1)| = 2^(W−1) fits).
  - Clear the iteration counter, remainders, quot_x, quot_y and div_by_zero.
  - Go to RUN, or go to FIX with div_by_zero=1 if divisor==0.
- RUN: restoring division, one quotient bit per lane per cycle, ITER cycles.
  - Numerator per lane is magnitude << FRAC_BITS (ITER bits).
  - Remainder is DATA_WIDTH+1 bits; internal quotient is ITER bits.
  - Counter reaching ITER−1 → FIX.
- FIX: apply sign = sign(dividend) XOR sign(divisor), then saturate.
  - Positive magnitude > 2^(W−1)−1 → 0x7FFF_FFFF.
  - Negative magnitude > 2^(W−1) → 0x8000_0000.
  - Register quot_x and quot_y. → DONE.
  - Divide-by-zero path: both quotients = 0.
- DONE: div_valid=1 for this cycle only. → IDLE.
- Rounding: truncate toward zero.
- div_start outside IDLE (RUN, FIX, DONE) is ignored; no queuing, and captured operands are unaffected.
- Reset (asynchronous): state=IDLE; div_valid, div_busy, div_by_zero, quot_x and quot_y all 0; counter and remainders 0.
  - Reset mid-operation aborts with no div_valid.

## Timing
- Start accepted in cycle 0 (IDLE, div_start=1).
- Normal path: RUN in cycles 1..ITER, FIX in cycle ITER+1, DONE/div_valid in cycle ITER+2. Default: div_valid in cycle 50.
- Divide by zero: FIX in cycle 1, div_valid in cycle 2.
- div_busy rises in cycle 1 and falls after the DONE cycle.
- Earliest next accepted start is the cycle after DONE.
- quot_x, quot_y and div_by_zero change only in FIX or on an accepted start. They are stable from the div_valid cycle until the next accepted start, covering the controller's load one cycle after valid.

## Test plan
- Basic:
  - Stimulus: dividend_x=0x0003_0000, dividend_y=0xFFFF_0000, divisor=0x0002_0000, one-cycle start.
  - Required: quot_x=0x0001_8000, quot_y=0xFFFF_8000.
  - Required: div_valid high only in cycle 50; div_busy high in cycles 1–50.
- Truncation:
  - Stimulus: dividend_x=0x0001_0000, dividend_y=0xFFFF_0000, divisor=0x0003_0000.
  - Required: quot_x=0x0000_5555, quot_y=0xFFFF_AAAB.
  - Required: values still held 5 cycles after valid.
- Saturation:
  - Stimulus: dividend_x=0x7FFF_0000, dividend_y=0x8000_0000, divisor=0x0000_0100.
  - Required: quot_x=0x7FFF_FFFF, quot_y=0x8000_0000.
- Divide by zero:
  - Stimulus: divisor=0, any dividends.
  - Required: div_by_zero=1, both quotients 0, div_valid in cycle 2.
  - Required: a following valid start clears div_by_zero.
- Ignored start:
  - Stimulus: second div_start with different operands in cycle 10.
  - Required: results equal those of the first operation; exactly one div_valid, in cycle 50.
- Reset mid-run:
  - Stimulus: Reset asserted in cycle 20.
  - Required: all outputs 0 immediately, no div_valid.
  - Required: a start after release gives correct results 50 cycles later.
